// File: rtl/vga_pkg.sv
// Shared VGA raster geometry: 640x480@60 defaults, totals, sync polarity.
// Colour sources import this so they agree with vga_sync_out.
package vga_pkg;

  localparam int VGA_CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int raster_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = raster_total(H_ACTIVE_DEF, H_FP_DEF,
                                            H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = raster_total(V_ACTIVE_DEF, V_FP_DEF,
                                            V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter with enable, terminal count,
// active-area and sync-window decodes.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int CNT_W      = VGA_CNT_W,
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_act,
  output logic             o_sync
);

  if (TOTAL - 1 >= (1 << CNT_W)) begin : g_width_chk
    $error("vga_axis_cnt: TOTAL-1 does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] S0   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] S1   = CNT_W'(SYNC_START + SYNC_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_tc   = w_tc;
  assign o_act  = (r_cnt < ACT);
  assign o_sync = (r_cnt >= S0) && (r_cnt < S1);

endmodule

// File: rtl/vga_sync_out.sv
// VGA pin driver: raster counters, registered sync/de/colour outputs.
// Optional frame_start pulse under VGA_SYNC_FRAME_PULSE_EN.
module vga_sync_out
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CNT_W    = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  input  logic             src_r,
  input  logic             src_g,
  input  logic             src_b,
  output logic             vga_r,
  output logic             vga_g,
  output logic             vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
`ifdef VGA_SYNC_FRAME_PULSE_EN
  output logic             frame_start,
`endif
  output logic             vga_de
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic             r_run;
  logic [CNT_W-1:0] w_hx, w_vy;
  logic             w_h_tc, w_v_tc, w_unused_vtc;
  logic             w_h_act, w_v_act, w_hwin, w_vwin, w_active;
  logic             r_r, r_g, r_b, r_hs, r_vs, r_de;

  // Raster holds at (0,0) for the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_run <= 1'b0;
    else     r_run <= 1'b1;
  end

  vga_axis_cnt #(
    .CNT_W(CNT_W), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
  ) u_h (
    .i_clk(clk), .i_rst(rst), .i_en(r_run),
    .o_cnt(w_hx), .o_tc(w_h_tc), .o_act(w_h_act), .o_sync(w_hwin)
  );

  vga_axis_cnt #(
    .CNT_W(CNT_W), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
  ) u_v (
    .i_clk(clk), .i_rst(rst), .i_en(r_run & w_h_tc),
    .o_cnt(w_vy), .o_tc(w_v_tc), .o_act(w_v_act), .o_sync(w_vwin)
  );

  assign w_unused_vtc = w_v_tc;
  assign w_active     = w_h_act & w_v_act;
  assign pix_x        = w_hx;
  assign pix_y        = w_vy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r  <= 1'b0;
      r_g  <= 1'b0;
      r_b  <= 1'b0;
      r_de <= 1'b0;
      r_hs <= ~SYNC_POL;
      r_vs <= ~SYNC_POL;
    end else if (r_run) begin
      r_r  <= w_active & src_r;
      r_g  <= w_active & src_g;
      r_b  <= w_active & src_b;
      r_de <= w_active;
      r_hs <= w_hwin ? SYNC_POL : ~SYNC_POL;
      r_vs <= w_vwin ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_SYNC_FRAME_PULSE_EN
  logic r_fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fs <= 1'b0;
    else     r_fs <= r_run && (w_hx == '0) && (w_vy == '0);
  end

  assign frame_start = r_fs;
`endif

  assign vga_r  = r_r;
  assign vga_g  = r_g;
  assign vga_b  = r_b;
  assign vga_de = r_de;
  assign vga_hs = r_hs;
  assign vga_vs = r_vs;

endmodule
